hazard3_fetch_bus_responder: RTL and testbench
==============================================

// Module: hazard3_fetch_bus_responder
// PURPOSE
// - Parametrised AHB-lite-style instruction-bus responder for frontend formal/sim benches.
// - Sits on the frontend mem_* port. Returns data that is a known function of address:
//   each halfword = its own byte address [16:1].
// - Adds programmable wait states (fixed, LFSR pseudo-random, address-derived) and
//   address-matched two-cycle bus errors.
// - Lets the fetch-match checker run with realistic stalls and faults.
// PARAMETERS
// - W_ADDR     32      address width
// - W_DATA     32      data width; 32 or 64 only (2 or 4 halfwords)
// - W_WAIT     3       wait-count width; max wait = 2^W_WAIT-1 cycles
// - LFSR_SEED  16'hace1  reset value of the 16-bit stall LFSR; must be nonzero
// - ERR_MASK   32'h0   address bits compared for error injection
// - ERR_MATCH  32'h0   error when (addr & ERR_MASK) == ERR_MATCH and cfg_err_en
// PORTS
// - clk            in   1       clock
// - rst_n          in   1       asynchronous, active-low reset
// - addr           in   W_ADDR  address-phase address
// - addr_vld       in   1       address-phase request
// - addr_rdy       out  1       hready; address accepted when addr_vld && addr_rdy
// - data           out  W_DATA  read data; zero unless data_vld && !data_err
// - data_vld       out  1       data-phase completion (hready && dphase active)
// - data_err       out  1       completion is a bus error; only with data_vld
// - cfg_stall_mode in   2       0 none, 1 fixed, 2 LFSR, 3 address-derived
// - cfg_wait       in   W_WAIT  fixed wait count (mode 1) / upper bound (mode 2)
// - cfg_err_en     in   1       enable error injection
// - cnt_req        out  16      accepted address phases, wraps at 2^16
// - cnt_err        out  16      error completions, wraps at 2^16
// BEHAVIOUR
// - Reset: state IDLE, addr_rdy=1, data_vld=0, data_err=0, data=0.
//   Counters=0; LFSR=LFSR_SEED; captured address=0.
// - FSM states: IDLE, WAIT, ERR1, ERR2.
//   - IDLE: addr_rdy=1, no data phase pending.
//   - On accept: capture addr; wait count w is loaded per mode.
//     - 0: w=0.  1: w=cfg_wait.
//     - 2: w=min(lfsr[W_WAIT-1:0], cfg_wait).
//     - 3: w=addr[W_WAIT+1:2].
//   - Error match at accept:
//     - w==0 -> next ERR1.
//     - else WAIT with err flag set.
//   - No match:
//     - w==0 -> next cycle completes (DATA cycle, addr_rdy=1).
//     - else WAIT.
//   - WAIT: addr_rdy=0; decrement w each cycle.
//     - At w==0: err flag -> ERR1; else complete with addr_rdy=1.
//   - ERR1: addr_rdy=0, data_vld=0, data_err=1 (hresp early cycle).
//   - ERR2: addr_rdy=1, data_vld=1, data_err=1, data=0.
//   - A new address may be accepted in any completing cycle (pipelined), including ERR2.
//   - No accept in WAIT/ERR1.
// - Zero-wait latency: accept in cycle N -> data_vld in N+1.
// - Data: halfword k (k=0..W_DATA/16-1) at byte address
//   A_k = {captured[W_ADDR-1:log2(W_DATA/8)], k[..], 1'b0}; data[16k+15:16k] = A_k[16:1].
// - LFSR: Galois x^16+x^14+x^13+x^11+1, advances every cycle out of reset.
// - Counters:
//   - cnt_req increments on accept.
//   - cnt_err increments in ERR2.
//   - Both wrap 16'hffff -> 0.
// - Config inputs are sampled only at accept; changes mid-phase have no effect on
//   the pending phase.
// - Async reset mid-phase: immediately IDLE, data_vld/data_err drop without completion.
// - addr_vld ignored while addr_rdy=0; no request buffering; at most one data phase
//   outstanding.
// - data_err never asserted with data_vld=0 except in ERR1.
// TESTING
// - T1 mode 0, W_DATA=32: accept addr 32'h40 ->
//   next cycle data_vld=1, data=32'h0021_0020, addr_rdy=1.
// - T2 mode 1, cfg_wait=3: accept 32'h100 -> addr_rdy low 3 cycles, then data=32'h0081_0080;
//   back-to-back request accepted on completion cycle.
// - T3 W_DATA=64: accept 32'h8 -> data=64'h0007_0006_0005_0004.
// - T4 ERR_MASK=32'hf000, ERR_MATCH=32'h2000, cfg_err_en=1, accept 32'h2004 ->
//   ERR1 (rdy=0, err=1), ERR2 (vld=1, err=1, data=0), cnt_err=1.
// - T5 mode 2, cfg_wait=2, 1000 random requests -> every wait <=2; cnt_req=1000;
//   data always matches address function.
// - T6 assert rst_n low during WAIT -> addr_rdy=1, data_vld=0, cnt_req=0 in the same cycle.

Source files
------------

// File: rtl/hazard3_fetch_bus_responder.sv
// Instruction-bus responder for frontend benches. Read data is a fixed function of the
// address (each halfword holds its own byte address [16:1]). The responder can insert
// fixed, pseudo-random or address-derived wait states and two-cycle bus errors on an
// address match.
module hazard3_fetch_bus_responder #(
    parameter int unsigned       W_ADDR    = 32,
    parameter int unsigned       W_DATA    = 32,
    parameter int unsigned       W_WAIT    = 3,
    parameter logic [15:0]       LFSR_SEED = 16'hace1,
    parameter logic [W_ADDR-1:0] ERR_MASK  = '0,
    parameter logic [W_ADDR-1:0] ERR_MATCH = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] addr,
    input  logic              addr_vld,
    output logic              addr_rdy,
    output logic [W_DATA-1:0] data,
    output logic              data_vld,
    output logic              data_err,
    input  logic [1:0]        cfg_stall_mode,
    input  logic [W_WAIT-1:0] cfg_wait,
    input  logic              cfg_err_en,
    output logic [15:0]       cnt_req,
    output logic [15:0]       cnt_err
);

    localparam int unsigned N_HW  = W_DATA / 16;
    localparam int unsigned W_OFF = $clog2(W_DATA / 8);
    localparam int unsigned W_K   = W_OFF - 1;
    // Only address bits [16:W_OFF] reach the data pattern, so only those are kept.
    localparam int unsigned W_CAP = 17 - W_OFF;

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e            state_q, state_d;
    logic              dphase_q, dphase_d;
    logic              err_pend_q, err_pend_d;
    logic [W_WAIT-1:0] wait_q, wait_d;
    logic [W_CAP-1:0]  cap_q, cap_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [15:0]       cnt_req_q, cnt_req_d;
    logic [15:0]       cnt_err_q, cnt_err_d;

    logic              accept;
    logic              err_hit;
    logic [W_WAIT-1:0] w_acc;
    logic [W_WAIT-1:0] lfsr_w;

    assign accept  = addr_vld && addr_rdy;
    assign err_hit = cfg_err_en && ((addr & ERR_MASK) == ERR_MATCH);
    assign lfsr_w  = lfsr_q[W_WAIT-1:0];
    assign cnt_req = cnt_req_q;
    assign cnt_err = cnt_err_q;

    // Wait count for a request accepted this cycle, from the configured stall mode.
    always_comb begin
        w_acc = '0;
        case (cfg_stall_mode)
            2'd0:    w_acc = '0;
            2'd1:    w_acc = cfg_wait;
            2'd2:    w_acc = (lfsr_w < cfg_wait) ? lfsr_w : cfg_wait;
            default: w_acc = addr[W_WAIT+1:2];
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        addr_rdy = 1'b0;
        data_vld = 1'b0;
        data_err = 1'b0;
        case (state_q)
            StIdle: begin
                addr_rdy = 1'b1;
                data_vld = dphase_q;
            end
            StWait: ;
            StErr1: data_err = 1'b1;
            StErr2: begin
                addr_rdy = 1'b1;
                data_vld = 1'b1;
                data_err = 1'b1;
            end
            default: ;
        endcase
    end

    // Read data: halfword k carries the byte address of that halfword, bits [16:1].
    always_comb begin
        data = '0;
        if (data_vld && !data_err) begin
            for (int k = 0; k < N_HW; k++) begin
                data[16*k +: 16] = {cap_q, W_K'(k)};
            end
        end
    end

    // Next-state logic: wait countdown, error sequence, and pipelined accepts.
    always_comb begin
        state_d    = state_q;
        dphase_d   = 1'b0;
        err_pend_d = err_pend_q;
        wait_d     = wait_q;
        cap_d      = cap_q;
        case (state_q)
            StWait: begin
                wait_d = wait_q - W_WAIT'(1);
                if (wait_q == W_WAIT'(1)) begin
                    if (err_pend_q) begin
                        state_d = StErr1;
                    end else begin
                        state_d  = StIdle;
                        dphase_d = 1'b1;
                    end
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
        // Accepts only happen in StIdle/StErr2, where addr_rdy is high.
        if (accept) begin
            cap_d      = addr[16:W_OFF];
            err_pend_d = 1'b0;
            if (w_acc == '0) begin
                if (err_hit) begin
                    state_d = StErr1;
                end else begin
                    state_d  = StIdle;
                    dphase_d = 1'b1;
                end
            end else begin
                state_d    = StWait;
                wait_d     = w_acc;
                err_pend_d = err_hit;
            end
        end
    end

    // Galois LFSR x^16+x^14+x^13+x^11+1 (right-shifting) and the event counters.
    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hb400 : 16'h0000);
        cnt_req_d = cnt_req_q + 16'(accept);
        cnt_err_d = cnt_err_q + 16'(state_q == StErr2);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dphase_q   <= 1'b0;
            err_pend_q <= 1'b0;
            wait_q     <= '0;
            cap_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            cnt_req_q  <= '0;
            cnt_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            dphase_q   <= dphase_d;
            err_pend_q <= err_pend_d;
            wait_q     <= wait_d;
            cap_q      <= cap_d;
            lfsr_q     <= lfsr_d;
            cnt_req_q  <= cnt_req_d;
            cnt_err_q  <= cnt_err_d;
        end
    end

endmodule

// File: tb/tb_hazard3_fetch_bus_responder.sv
// Bench for hazard3_fetch_bus_responder: a 32-bit and a 64-bit instance share stimulus
// and are checked against an address-function model and request/error counts.
module tb_hazard3_fetch_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        addr_vld = 1'b0;
    logic [1:0]  mode = '0;
    logic [2:0]  cfg_wait = '0;
    logic        err_en = 1'b0;

    logic        rdy32, vld32, err32, rdy64, vld64, err64;
    logic [31:0] dat32;
    logic [63:0] dat64;
    logic [15:0] cr32, ce32, cr64, ce64;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_req  = 0;
    int exp_err  = 0;

    always #5 clk = ~clk;

    hazard3_fetch_bus_responder #(
        .W_ADDR(32), .W_DATA(32), .W_WAIT(3), .LFSR_SEED(16'hace1),
        .ERR_MASK(32'hf000), .ERR_MATCH(32'h2000)
    ) dut32 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .addr_vld(addr_vld), .addr_rdy(rdy32),
        .data(dat32), .data_vld(vld32), .data_err(err32), .cfg_stall_mode(mode),
        .cfg_wait(cfg_wait), .cfg_err_en(err_en), .cnt_req(cr32), .cnt_err(ce32)
    );

    hazard3_fetch_bus_responder #(
        .W_ADDR(32), .W_DATA(64), .W_WAIT(3), .LFSR_SEED(16'hace1),
        .ERR_MASK(32'hf000), .ERR_MATCH(32'h2000)
    ) dut64 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .addr_vld(addr_vld), .addr_rdy(rdy64),
        .data(dat64), .data_vld(vld64), .data_err(err64), .cfg_stall_mode(mode),
        .cfg_wait(cfg_wait), .cfg_err_en(err_en), .cnt_req(cr64), .cnt_err(ce64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Halfwords of the aligned beat, each equal to its own byte address divided by two.
    function automatic logic [63:0] exp_data(input logic [31:0] a, input int bytes);
        logic [31:0] base;
        logic [31:0] b;
        logic [63:0] r;
        r = '0;
        base = a - (a % 32'(bytes));
        for (int k = 0; k < bytes / 2; k++) begin
            b = base + 32'(2 * k);
            r[16*k +: 16] = b[16:1];
        end
        return r;
    endfunction

    task automatic idle(input int n);
        addr_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_counts();
        chk("cnt_req32", 64'(cr32), 64'(exp_req));
        chk("cnt_req64", 64'(cr64), 64'(exp_req));
        chk("cnt_err32", 64'(ce32), 64'(exp_err));
        chk("cnt_err64", 64'(ce64), 64'(exp_err));
    endtask

    // Issue one request at a negedge; returns at the negedge of its completion cycle, so a
    // following call is accepted back-to-back. scramble disturbs config and addr_vld while
    // the phase is pending.
    task automatic txn(input logic [31:0] a, input bit scramble);
        int         w_exp;
        int         w_max;
        int         n;
        bit         hit;
        logic [1:0] m0;
        logic [2:0] w0;
        logic       e0;
        m0 = mode;
        w0 = cfg_wait;
        e0 = err_en;
        case (m0)
            2'd0:    w_exp = 0;
            2'd1:    w_exp = int'(w0);
            2'd2:    w_exp = -1;
            default: w_exp = int'((a >> 2) & 32'h7);
        endcase
        w_max = (m0 == 2'd2) ? int'(w0) : w_exp;
        hit = e0 && ((a & 32'hf000) == 32'h2000);
        addr = a;
        addr_vld = 1'b1;
        chk("rdy_issue32", 64'(rdy32), 64'd1);
        chk("rdy_issue64", 64'(rdy64), 64'd1);
        @(negedge clk);
        exp_req = (exp_req + 1) & 32'hffff;
        addr = $urandom();
        addr_vld = scramble;
        if (scramble) begin
            mode = 2'($urandom());
            cfg_wait = 3'($urandom());
            err_en = 1'($urandom());
        end
        n = 0;
        while (!vld32 && !err32 && n < 20) begin
            chk("stall_rdy32", 64'(rdy32), 64'd0);
            chk("stall_rdy64", 64'(rdy64), 64'd0);
            chk("stall_data32", 64'(dat32), 64'd0);
            n++;
            @(negedge clk);
        end
        addr_vld = 1'b0;
        if (m0 == 2'd2) chk("wait_bound", 64'(n <= w_max), 64'd1);
        else            chk("wait_len", 64'(n), 64'(w_exp));
        if (hit) begin
            chk("err1_err", 64'(err32), 64'd1);
            chk("err1_vld", 64'(vld32), 64'd0);
            chk("err1_rdy", 64'(rdy32), 64'd0);
            chk("err1_err64", 64'(err64), 64'd1);
            @(negedge clk);
            chk("err2_err", 64'(err32), 64'd1);
            chk("err2_vld", 64'(vld32), 64'd1);
            chk("err2_rdy", 64'(rdy32), 64'd1);
            chk("err2_data32", 64'(dat32), 64'd0);
            chk("err2_data64", dat64, 64'd0);
            chk("err2_vld64", 64'(vld64), 64'd1);
        end else begin
            chk("done_vld", 64'(vld32), 64'd1);
            chk("done_err", 64'(err32), 64'd0);
            chk("done_rdy", 64'(rdy32), 64'd1);
            chk("data32", 64'(dat32), exp_data(a, 4));
            chk("data64", dat64, exp_data(a, 8));
            chk("done_vld64", 64'(vld64), 64'd1);
        end
        chk_counts();
        if (hit) exp_err = (exp_err + 1) & 32'hffff;
        mode = m0;
        cfg_wait = w0;
        err_en = e0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        addr_vld = 1'b0;
        #1;
        exp_req = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_rdy", 64'(rdy32), 64'd1);
        chk("rst_vld", 64'(vld32), 64'd0);
        chk("rst_err", 64'(err32), 64'd0);
        chk("rst_data", 64'(dat32), 64'd0);
        chk_counts();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: zero-wait read
        mode = 2'd0;
        txn(32'h40, 1'b0);
        chk("t1_data", 64'(dat32), 64'h0021_0020);
        idle(1);
        chk("t1_idle_vld", 64'(vld32), 64'd0);

        // T2: fixed three-cycle stall, then back-to-back on the completion cycle
        mode = 2'd1;
        cfg_wait = 3'd3;
        txn(32'h100, 1'b0);
        chk("t2_data", 64'(dat32), 64'h0081_0080);
        txn(32'h104, 1'b1);
        txn(32'h1f6, 1'b1);
        idle(2);

        // T3: 64-bit beat
        mode = 2'd0;
        txn(32'h8, 1'b0);
        chk("t3_data", dat64, 64'h0007_0006_0005_0004);
        idle(1);

        // T4: address-matched error, with and without preceding waits
        err_en = 1'b1;
        txn(32'h2004, 1'b0);
        idle(1);
        chk("t4_cnt_err", 64'(ce32), 64'd1);
        mode = 2'd1;
        cfg_wait = 3'd2;
        txn(32'h2abc, 1'b0);
        mode = 2'd0;
        txn(32'h300, 1'b0);   // accepted in the ERR2 cycle
        txn(32'h2010, 1'b0);
        txn(32'h2012, 1'b0);
        err_en = 1'b0;
        txn(32'h2004, 1'b0);
        idle(1);
        chk_counts();

        // Address-derived waits
        mode = 2'd3;
        for (int i = 0; i < 16; i++) begin
            txn($urandom(), 1'(i % 3 == 0));
            if (i % 2 == 1) idle(1);
        end
        idle(1);

        // T5: LFSR waits bounded by cfg_wait over 1000 random requests
        do_reset();
        mode = 2'd2;
        cfg_wait = 3'd2;
        for (int i = 0; i < 1000; i++) begin
            txn($urandom(), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
        chk("t5_cnt_req", 64'(cr32), 64'd1000);
        chk("t5_cnt_req64", 64'(cr64), 64'd1000);

        // Wider LFSR bound with errors enabled
        cfg_wait = 3'd7;
        err_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            txn({$urandom_range(0, 3) == 0 ? 20'h00002 : 20'(i + 5), 12'($urandom())}, 1'b0);
        end
        err_en = 1'b0;
        idle(1);
        chk_counts();

        // T6: asynchronous reset in the middle of a wait phase
        mode = 2'd1;
        cfg_wait = 3'd7;
        addr = 32'h500;
        addr_vld = 1'b1;
        @(negedge clk);
        addr_vld = 1'b0;
        chk("t6_wait_rdy", 64'(rdy32), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rdy", 64'(rdy32), 64'd1);
        chk("t6_vld", 64'(vld32), 64'd0);
        chk("t6_err", 64'(err32), 64'd0);
        chk("t6_cnt_req", 64'(cr32), 64'd0);
        chk("t6_rdy64", 64'(rdy64), 64'd1);
        exp_req = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_vld", 64'(vld32), 64'd0);
        mode = 2'd0;
        txn(32'h1234, 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
